// File: rtl/issue_retire_if.sv
// Dispatch, writeback and status bundle between the thread front end and issue_retire.
// The front end drives the master side; issue_retire is the slave.
interface issue_retire_if #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NUM_ALUS    = 1
);
    logic [NUM_ALUS-1:0][2:0]  disp_thread;
    logic [NUM_ALUS-1:0][6:0]  disp_op;
    logic [NUM_ALUS-1:0][31:0] disp_data;
    logic                      disp_stall;
    logic                      wb_valid;
    logic [2:0]                wb_thread;
    logic [31:0]               wb_data;
    logic                      wb_ready;
    logic [NUM_THREADS-1:0]    thread_busy;
    logic                      div_busy;
    logic [NUM_THREADS-1:0]    retire_pulse;
    logic [2:0]                err;

    modport master (
        output disp_thread, disp_op, disp_data, wb_ready,
        input  disp_stall, wb_valid, wb_thread, wb_data, thread_busy, div_busy, retire_pulse, err
    );

    modport slave (
        input  disp_thread, disp_op, disp_data, wb_ready,
        output disp_stall, wb_valid, wb_thread, wb_data, thread_busy, div_busy, retire_pulse, err
    );
endinterface

// File: rtl/issue_retire.sv
// Issue/retire back end: tracks issued ops through ALU pipes or the shared divider and retires
// them in order to the register-file write port. Optional same-cycle bypass: RETIRE_BYPASS_EN.
module issue_retire #(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NUM_ALUS    = 1,
    parameter int unsigned ALU_LAT     = 1,
    parameter int unsigned DIV_LAT     = 3,
    parameter int unsigned QDEPTH      = 4,
    parameter logic [6:0]  DIV_OP      = 7'd38
) (
    input logic           clk,
    input logic           rst,
    issue_retire_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned NCOMP = NUM_ALUS + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    // One shift pipe per slot; stage ALU_LAT-1 is the exit stage
    logic [NUM_ALUS-1:0][ALU_LAT-1:0]       pipe_vld_q, pipe_vld_d;
    logic [NUM_ALUS-1:0][ALU_LAT-1:0][2:0]  pipe_thr_q, pipe_thr_d;
    logic [NUM_ALUS-1:0][ALU_LAT-1:0][31:0] pipe_data_q, pipe_data_d;

    logic [2:0]  div_cnt_q, div_cnt_d;
    logic [2:0]  div_thr_q, div_thr_d;
    logic [31:0] div_data_q, div_data_d;

    logic [QDEPTH-1:0][2:0]  q_thr_q, q_thr_d;
    logic [QDEPTH-1:0][31:0] q_data_q, q_data_d;
    ptr_t                    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wp;
    cnt_t                    count_q, count_d, n_push;

    logic [NUM_THREADS-1:0] busy_q, busy_d, retire_q, retire_d, claim, busy_set;
    logic [2:0]             err_q, err_d;

    logic [NCOMP-1:0]       comp_vld;
    logic [NCOMP-1:0][2:0]  comp_thr;
    logic [NCOMP-1:0][31:0] comp_data;

    logic [NUM_ALUS-1:0] slot_vld, slot_div, slot_hit, slot_div_blk, alu_acc;
    logic                div_acc;
    logic [2:0]          div_thr_new;
    logic [31:0]         div_data_new;

    logic        stall, div_busy;
    logic        byp_vld, byp_take, q_pop, pop;
    logic [2:0]  byp_thr, wb_thr;
    logic [31:0] byp_data;
    int unsigned inflight;

    assign div_busy = (div_cnt_q != 3'd0);

    // Credit check: everything already queued or in flight plus a full issue cycle must fit
    always_comb begin
        inflight = div_busy ? 32'd1 : 32'd0;
        for (int s = 0; s < int'(NUM_ALUS); s++) begin
            for (int k = 0; k < int'(ALU_LAT); k++) begin
                inflight = inflight + 32'(pipe_vld_q[s][k]);
            end
        end
        stall = (32'(count_q) + inflight + NUM_ALUS) > QDEPTH;
    end

    // Completion order into the queue: divider first, then ALU slots ascending
    always_comb begin
        comp_vld[0]  = (div_cnt_q == 3'd1);
        comp_thr[0]  = div_thr_q;
        comp_data[0] = div_data_q;
        for (int s = 0; s < int'(NUM_ALUS); s++) begin
            comp_vld[s+1]  = pipe_vld_q[s][ALU_LAT-1];
            comp_thr[s+1]  = pipe_thr_q[s][ALU_LAT-1];
            comp_data[s+1] = pipe_data_q[s][ALU_LAT-1];
        end
    end

`ifdef RETIRE_BYPASS_EN
    int unsigned comp_n;

    always_comb begin
        comp_n   = 0;
        byp_thr  = '0;
        byp_data = '0;
        for (int c = 0; c < int'(NCOMP); c++) begin
            if (comp_vld[c]) begin
                comp_n   = comp_n + 1;
                byp_thr  = comp_thr[c];
                byp_data = comp_data[c];
            end
        end
        byp_vld = (count_q == '0) && (comp_n == 1);
    end
`else
    assign byp_vld  = 1'b0;
    assign byp_thr  = '0;
    assign byp_data = '0;
`endif

    assign wb_thr   = byp_vld ? byp_thr : q_thr_q[rd_ptr_q];
    assign q_pop    = (count_q != '0) && bus.wb_ready;
    assign byp_take = byp_vld && bus.wb_ready;
    assign pop      = q_pop || byp_take;

    // Issue acceptance; a dropped slot only records its error bits
    always_comb begin
        alu_acc      = '0;
        div_acc      = 1'b0;
        div_thr_new  = '0;
        div_data_new = '0;
        claim        = '0;
        busy_set     = '0;
        err_d        = err_q;
        for (int s = 0; s < int'(NUM_ALUS); s++) begin
            slot_vld[s] = bus.disp_thread[s] < 3'(NUM_THREADS);
            slot_div[s] = bus.disp_op[s] == DIV_OP;
            slot_hit[s] = 1'b0;
            for (int t = 0; t < int'(NUM_THREADS); t++) begin
                if (bus.disp_thread[s] == 3'(t) && (busy_q[t] || claim[t])) slot_hit[s] = 1'b1;
            end
            slot_div_blk[s] = slot_div[s] && (div_busy || div_acc);
            if (slot_vld[s]) begin
                if (slot_hit[s])     err_d[0] = 1'b1;
                if (slot_div_blk[s]) err_d[1] = 1'b1;
                if (stall)           err_d[2] = 1'b1;
                if (!slot_hit[s] && !slot_div_blk[s] && !stall) begin
                    if (slot_div[s]) begin
                        div_acc      = 1'b1;
                        div_thr_new  = bus.disp_thread[s];
                        div_data_new = bus.disp_data[s];
                    end else begin
                        alu_acc[s] = 1'b1;
                    end
                    for (int t = 0; t < int'(NUM_THREADS); t++) begin
                        if (bus.disp_thread[s] == 3'(t)) busy_set[t] = 1'b1;
                    end
                end
                for (int t = 0; t < int'(NUM_THREADS); t++) begin
                    if (bus.disp_thread[s] == 3'(t)) claim[t] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pipe_vld_d  = pipe_vld_q;
        pipe_thr_d  = pipe_thr_q;
        pipe_data_d = pipe_data_q;
        for (int s = 0; s < int'(NUM_ALUS); s++) begin
            for (int k = int'(ALU_LAT) - 1; k > 0; k--) begin
                pipe_vld_d[s][k]  = pipe_vld_q[s][k-1];
                pipe_thr_d[s][k]  = pipe_thr_q[s][k-1];
                pipe_data_d[s][k] = pipe_data_q[s][k-1];
            end
            pipe_vld_d[s][0]  = alu_acc[s];
            pipe_thr_d[s][0]  = bus.disp_thread[s];
            pipe_data_d[s][0] = bus.disp_data[s];
        end

        div_cnt_d  = div_cnt_q;
        div_thr_d  = div_thr_q;
        div_data_d = div_data_q;
        if (div_acc) begin
            div_cnt_d  = 3'(DIV_LAT);
            div_thr_d  = div_thr_new;
            div_data_d = div_data_new;
        end else if (div_busy) begin
            div_cnt_d = div_cnt_q - 3'd1;
        end

        // A bypassed completion is consumed directly and never enters the queue
        q_thr_d  = q_thr_q;
        q_data_d = q_data_q;
        wp       = wr_ptr_q;
        n_push   = '0;
        for (int c = 0; c < int'(NCOMP); c++) begin
            if (comp_vld[c] && !byp_take) begin
                q_thr_d[wp]  = comp_thr[c];
                q_data_d[wp] = comp_data[c];
                wp           = wp + ptr_t'(1);
                n_push       = n_push + cnt_t'(1);
            end
        end
        wr_ptr_d = wp;
        rd_ptr_d = rd_ptr_q + ptr_t'(q_pop);
        count_d  = count_q + n_push - cnt_t'(q_pop);

        busy_d   = busy_q | busy_set;
        retire_d = '0;
        for (int t = 0; t < int'(NUM_THREADS); t++) begin
            if (pop && wb_thr == 3'(t)) begin
                busy_d[t]   = 1'b0;
                retire_d[t] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q  <= '0;
            pipe_thr_q  <= '0;
            pipe_data_q <= '0;
            div_cnt_q   <= '0;
            div_thr_q   <= '0;
            div_data_q  <= '0;
            q_thr_q     <= '0;
            q_data_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= '0;
            retire_q    <= '0;
            err_q       <= '0;
        end else begin
            pipe_vld_q  <= pipe_vld_d;
            pipe_thr_q  <= pipe_thr_d;
            pipe_data_q <= pipe_data_d;
            div_cnt_q   <= div_cnt_d;
            div_thr_q   <= div_thr_d;
            div_data_q  <= div_data_d;
            q_thr_q     <= q_thr_d;
            q_data_q    <= q_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            retire_q    <= retire_d;
            err_q       <= err_d;
        end
    end

    assign bus.disp_stall   = stall;
    assign bus.wb_valid     = (count_q != '0) || byp_vld;
    assign bus.wb_thread    = wb_thr;
    assign bus.wb_data      = byp_vld ? byp_data : q_data_q[rd_ptr_q];
    assign bus.thread_busy  = busy_q;
    assign bus.div_busy     = div_busy;
    assign bus.retire_pulse = retire_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_issue_retire.sv
// Bench for issue_retire: directed scenarios plus random traffic, checked every cycle against a
// reference model that tracks ops by absolute completion cycle and a FIFO of retiring entries.
module tb_issue_retire;
    localparam int         NT      = 4;
    localparam int         ALU_LAT = 1;
    localparam int         DIV_LAT = 3;
    localparam int         QDEPTH  = 4;
    localparam logic [6:0] DIV_OP  = 7'd38;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_retire_if #(.NUM_THREADS(NT), .NUM_ALUS(1)) bus ();

    issue_retire dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]  thr;
        logic [31:0] data;
    } ent_t;

    typedef struct packed {
        logic [2:0]  thr;
        logic [31:0] data;
        bit          is_div;
        int          due;
    } fly_t;

    ent_t       fifo[$];
    fly_t       fly[$];
    logic [7:0] m_busy;
    logic [7:0] m_retire;
    logic [2:0] m_err;
    int         cyc;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_stall();
        return (fifo.size() + fly.size() + 1) > QDEPTH;
    endfunction

    function automatic bit m_div_busy();
        foreach (fly[i]) if (fly[i].is_div) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        check("wb_valid", 32'(bus.wb_valid), 32'(fifo.size() != 0));
        if (fifo.size() != 0) begin
            check("wb_thread", 32'(bus.wb_thread), 32'(fifo[0].thr));
            check("wb_data", bus.wb_data, fifo[0].data);
        end
        check("disp_stall", 32'(bus.disp_stall), 32'(m_stall()));
        check("div_busy", 32'(bus.div_busy), 32'(m_div_busy()));
        check("thread_busy", 32'(bus.thread_busy), 32'(m_busy[3:0]));
        check("retire_pulse", 32'(bus.retire_pulse), 32'(m_retire[3:0]));
        check("err", 32'(bus.err), 32'(m_err));
    endtask

    // Advance the model over the clock edge that ends the current cycle
    task automatic model_step(input logic [2:0] thr, input logic [6:0] op, input logic [31:0] d,
                              input logic rdy, input logic r);
        bit         stall, divb, take;
        fly_t       nf;
        fly_t       keep[$];
        ent_t       e;
        logic [7:0] nret;
        if (r) begin
            fifo.delete();
            fly.delete();
            m_busy   = '0;
            m_retire = '0;
            m_err    = '0;
            cyc++;
            return;
        end
        stall = m_stall();
        divb  = m_div_busy();
        take  = 1'b0;
        if (int'(thr) < NT) begin
            take = 1'b1;
            if (m_busy[thr])              begin m_err[0] = 1'b1; take = 1'b0; end
            if (op == DIV_OP && divb)     begin m_err[1] = 1'b1; take = 1'b0; end
            if (stall)                    begin m_err[2] = 1'b1; take = 1'b0; end
        end
        nret = '0;
        if (fifo.size() != 0 && rdy) begin
            e            = fifo.pop_front();
            nret[e.thr]  = 1'b1;
            m_busy[e.thr] = 1'b0;
        end
        foreach (fly[i]) if (fly[i].is_div && fly[i].due == cyc)
            fifo.push_back(ent_t'{thr: fly[i].thr, data: fly[i].data});
        foreach (fly[i]) if (!fly[i].is_div && fly[i].due == cyc)
            fifo.push_back(ent_t'{thr: fly[i].thr, data: fly[i].data});
        foreach (fly[i]) if (fly[i].due != cyc) keep.push_back(fly[i]);
        fly = keep;
        if (take) begin
            nf.thr    = thr;
            nf.data   = d;
            nf.is_div = (op == DIV_OP);
            nf.due    = cyc + (nf.is_div ? DIV_LAT : ALU_LAT);
            fly.push_back(nf);
            m_busy[thr] = 1'b1;
        end
        m_retire = nret;
        cyc++;
    endtask

    task automatic step(input logic [2:0] thr, input logic [6:0] op, input logic [31:0] d,
                        input logic rdy, input logic r);
        @(negedge clk);
        check_outputs();
        rst                 = r;
        bus.disp_thread[0]  = thr;
        bus.disp_op[0]      = op;
        bus.disp_data[0]    = d;
        bus.wb_ready        = rdy;
        model_step(thr, op, d, rdy, r);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(3'd4, 7'd0, 32'd0, rdy, 1'b0);
    endtask

    initial begin
        logic [2:0]  thr;
        logic [6:0]  op;
        logic [31:0] d;
        logic        rdy;
        logic        r;

        cyc                = 0;
        rst                = 1'b1;
        bus.disp_thread[0] = 3'd4;
        bus.disp_op[0]     = 7'd0;
        bus.disp_data[0]   = 32'd0;
        bus.wb_ready       = 1'b1;
        model_step(3'd4, 7'd0, 32'd0, 1'b1, 1'b1);

        // Reset state, then idle slots
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b1);
        check("rst_wb_thread", 32'(bus.wb_thread), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        idle(10, 1'b1);

        // Single ALU op
        step(3'd2, 7'd5, 32'hA5A5_0001, 1'b1, 1'b0);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        check("alu_busy", 32'(bus.thread_busy), 32'h4);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        check("alu_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("alu_wb_thread", 32'(bus.wb_thread), 32'd2);
        check("alu_wb_data", bus.wb_data, 32'hA5A5_0001);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        check("alu_retire", 32'(bus.retire_pulse), 32'h4);
        idle(3, 1'b1);

        // Divider collision, then reissue once the divider frees
        step(3'd1, DIV_OP, 32'hD1D1_0001, 1'b1, 1'b0);
        step(3'd0, DIV_OP, 32'hD0D0_0000, 1'b1, 1'b0);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        check("div_collide_err", 32'(bus.err), 32'd2);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        step(3'd0, DIV_OP, 32'hD0D0_0002, 1'b1, 1'b0);
        check("div_free_wb_thread", 32'(bus.wb_thread), 32'd1);
        check("div_free", 32'(bus.div_busy), 32'd0);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        check("div_reissue_busy", 32'(bus.div_busy), 32'd1);
        idle(6, 1'b1);

        // Divide and ALU op completing together: divider goes first
        step(3'd0, DIV_OP, 32'h0000_D000, 1'b1, 1'b0);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        step(3'd1, 7'd5, 32'h0000_A001, 1'b1, 1'b0);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        check("order_first", 32'(bus.wb_thread), 32'd0);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        check("order_second", 32'(bus.wb_thread), 32'd1);
        idle(3, 1'b1);

        // Back-pressure until credits run out, issue while stalled, then drain
        for (int t = 0; t < 4; t++) step(3'(t), 7'd5, 32'hC000_0000 + 32'(t), 1'b0, 1'b0);
        step(3'd0, 7'd5, 32'hBAD0_0000, 1'b0, 1'b0);
        check("credit_stall", 32'(bus.disp_stall), 32'd1);
        step(3'd4, 7'd0, 32'd0, 1'b0, 1'b0);
        check("stall_err", 32'(bus.err[2]), 32'd1);
        idle(2, 1'b0);
        idle(8, 1'b1);

        // Reset with three queued entries
        for (int t = 0; t < 3; t++) step(3'(t), 7'd9, 32'hE000_0000 + 32'(t), 1'b0, 1'b0);
        idle(3, 1'b0);
        step(3'd4, 7'd0, 32'd0, 1'b0, 1'b1);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        check("flush_valid", 32'(bus.wb_valid), 32'd0);
        check("flush_busy", 32'(bus.thread_busy), 32'd0);
        step(3'd4, 7'd0, 32'd0, 1'b1, 1'b0);
        check("flush_no_retire", 32'(bus.retire_pulse), 32'd0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            thr = 3'($urandom_range(0, 5));
            op  = ($urandom_range(0, 2) == 0) ? DIV_OP : 7'($urandom_range(0, 127));
            d   = $urandom();
            rdy = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 149) == 0);
            step(thr, op, d, rdy, r);
        end
        idle(12, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/issue_retire.md
# issue_retire

Back end of the thread dispatch path. Accepts per-ALU issue slots (thread index plus opcode id) and tracks each issued operation through its execution latency: single-cycle ALU ops or the shared multi-cycle divider. Retires results in order through a completion queue to the single register-file write port. Returns per-thread busy/retire status and divider occupancy to the front end, so a thread is never issued twice while in flight.

## Interface
Parameters:
- NUM_THREADS, 4, hardware threads; thread index NUM_THREADS (=4) means "no issue"
- NUM_ALUS, 1, issue slots per cycle
- ALU_LAT, 1, non-divide latency in cycles (1..3)
- DIV_LAT, 3, divide latency in cycles (2..7)
- QDEPTH, 4, completion queue entries (power of two, >= NUM_ALUS+1)
- DIV_OP, 7'd38, opcode id of divide

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- disp_thread  in  [NUM_ALUS][3]  issued thread index per slot; 4 = idle
- disp_op  in  [NUM_ALUS][7]  opcode id per slot
- disp_data  in  [NUM_ALUS][32]  result payload, carried unchanged to writeback
- disp_stall  out  1  front end must not issue this cycle
- wb_valid  out  1  head entry available
- wb_thread  out  3  thread of head entry
- wb_data  out  32  payload of head entry
- wb_ready  in  1  register file accepts head entry
- thread_busy  out  NUM_THREADS  thread has an op in flight or queued
- div_busy  out  1  divider occupied
- retire_pulse  out  NUM_THREADS  one-cycle pulse per retired op
- err  out  3  sticky: [0] issue to busy thread, [1] divide while div_busy, [2] issue while disp_stall

## Operation
- Slot valid when disp_thread < NUM_THREADS. Valid slots are sampled at the rising edge ending cycle c.
- Drop rules: a valid slot is dropped and its err bit set in any of these cases:
  - its thread is already busy, or another slot in the same cycle targets the same thread (higher slot index is dropped);
  - it is a divide and div_busy is high, or a lower slot in the same cycle already took the divider;
  - disp_stall is high (err[2]).
  - Dropped slots have no other effect.
- Non-divide ops enter a shift pipeline of ALU_LAT stages per slot.
- A divide loads the divider: 3-bit down-counter set to DIV_LAT, plus a thread/data holding register.
- Completion is when a pipe stage exits or the divider counter reaches 0. Completions are pushed into the queue in the same cycle in fixed order: divider first, then ALU slots ascending.
- Credit rule: disp_stall = (queue_count + inflight_count + NUM_ALUS > QDEPTH). This guarantees the queue never overflows.
- Head entry is popped on wb_valid && wb_ready. The thread_busy bit clears and retire_pulse[t] fires in the following cycle.
- Queue pointers are log2(QDEPTH) bits with natural wrap-around. The count is log2(QDEPTH)+1 bits.
- A simultaneous push and pop on a full queue is legal; the count is unchanged.
- Reset values: wb_valid=0, wb_thread=0, wb_data=0, disp_stall=0, thread_busy=0, div_busy=0, retire_pulse=0, err=0. The queue, pipes and divider are emptied.
- Reset mid-operation discards all in-flight and queued entries with no retire_pulse.

## Timing
- thread_busy[t] rises in cycle c+1 after issue in cycle c.
- Non-divide op, empty queue, wb_ready high: wb_valid in cycle c+ALU_LAT+1; retire_pulse in c+ALU_LAT+2.
- Divide: div_busy high in cycles c+1 .. c+DIV_LAT. wb_valid in c+DIV_LAT+1. A new divide may issue in cycle c+DIV_LAT+1.
- wb_valid/wb_thread/wb_data are driven from registers. They are held stable while wb_valid && !wb_ready.
- Throughput: one retire per cycle.

## Configuration
- RETIRE_BYPASS_EN defined: when the queue is empty and exactly one op completes in a cycle, it is presented on wb_* in that same cycle, driven combinationally from the completing stage. All latencies above shrink by 1 in that case. If wb_ready is low, the entry is pushed normally.
- RETIRE_BYPASS_EN undefined: all completions pass through the queue; latencies as stated.

## Test plan
- Reset then idle slots: all outputs 0 for 10 cycles; err=0.
- Issue thread 2, op 5, data 0xA5A5_0001 in cycle 3, wb_ready=1: thread_busy=4'b0100 from cycle 4; wb_valid/thread 2/0xA5A5_0001 in cycle 5; retire_pulse=4'b0100 in cycle 6.
- Divide on thread 1 in cycle 3, then divide on thread 0 in cycle 4: second divide dropped, err=3'b010. Thread 1 data appears in cycle 7. A divide on thread 0 in cycle 7 is accepted.
- Divide thread 0 in cycle 3, ALU op thread 1 in cycle 5 (ALU_LAT=1, DIV_LAT=3): both complete in cycle 6. Queue order is thread 0 then thread 1, on consecutive wb cycles 7 and 8.
- wb_ready=0, issue threads 0..3 on consecutive cycles: disp_stall asserts once credits are exhausted. An issue while stalled sets err[2]. Release wb_ready: four in-order retires 0,1,2,3, no loss.
- Assert rst for one cycle with three entries queued: wb_valid=0 and thread_busy=0 next cycle; no retire_pulse.
